vga_tile_scan: RTL and testbench

VGA_TILE_SCAN -- requirements
Module: vga_tile_scan

---
 rtl/vga_tile_scan.sv | 77 +++++++
 tb/tb_vga_tile_scan.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_tile_scan.sv
// vga_tile_scan: VGA timing with tile row/col lookup, i_draw pipeline alignment and RGB333 output
module vga_tile_scan #(
   parameter int         H_ACTIVE     = 640,
   parameter int         H_FRONT      = 16,
   parameter int         H_SYNC       = 96,
   parameter int         H_BACK       = 48,
   parameter int         V_ACTIVE     = 480,
   parameter int         V_FRONT      = 10,
   parameter int         V_SYNC       = 2,
   parameter int         V_BACK       = 33,
   parameter int         TILE_SHIFT   = 4,
   parameter int         DRAW_LATENCY = 1,
   parameter logic [8:0] FG_COLOR     = 9'h1FF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_draw,
   output logic [5:0] o_row,
   output logic [5:0] o_col,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [2:0] o_red,
   output logic [2:0] o_grn,
   output logic [2:0] o_blu,
   output logic       o_frame_start
);
   localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic run, h_end, v_end, act, hs_raw, vs_raw;
   logic [DRAW_LATENCY:0] act_p, hs_p, vs_p;
   always_comb begin
      h_end  = h == HW'(HT - 1);
      v_end  = v == VW'(VT - 1);
      act    = run && h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
      hs_raw = !(run && h >= HW'(H_ACTIVE + H_FRONT) && h < HW'(H_ACTIVE + H_FRONT + H_SYNC));
      vs_raw = !(run && v >= VW'(V_ACTIVE + V_FRONT) && v < VW'(V_ACTIVE + V_FRONT + V_SYNC));
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         run <= 1'b0;
         h   <= '0;
         v   <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end)
               v <= v_end ? '0 : v + 1'b1;
         end
      end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         o_row         <= '1;
         o_col         <= '1;
         o_frame_start <= 1'b0;
         act_p         <= '0;
         hs_p          <= '1;
         vs_p          <= '1;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         {o_red, o_grn, o_blu} <= '0;
      end else begin
         o_row         <= act ? 6'(v >> TILE_SHIFT) : '1;
         o_col         <= act ? 6'(h >> TILE_SHIFT) : '1;
         o_frame_start <= run && h == '0 && v == '0;
         act_p         <= {act_p[DRAW_LATENCY-1:0], act};
         hs_p          <= {hs_p[DRAW_LATENCY-1:0], hs_raw};
         vs_p          <= {vs_p[DRAW_LATENCY-1:0], vs_raw};
         o_hsync       <= hs_p[DRAW_LATENCY];
         o_vsync       <= vs_p[DRAW_LATENCY];
         {o_red, o_grn, o_blu} <= act_p[DRAW_LATENCY] && i_draw ? FG_COLOR : '0;
      end
endmodule

// File: tb/tb_vga_tile_scan.sv
// tb_vga_tile_scan: scoreboard bench for vga_tile_scan at DRAW_LATENCY 1 and 3
module tb_vga_tile_scan;
   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 48, VF = 2, VS = 2, VB = 3;
   localparam int TS = 3;
   localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, F = HT * VT;
   localparam logic [8:0] FG = 9'h1A5;
   typedef struct {int q; logic hs; logic vs; logic [8:0] rgb;} exp_t;
   logic clk = 0, rst = 1, draw_a = 0, draw_b = 0;
   logic [5:0] row_a, col_a, row_b, col_b;
   logic hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
   logic [2:0] r_a, g_a, b_a, r_b, g_b, b_b;
   exp_t qa[$], qb[$];
   logic dqa[$], dqb[$];
   int total = 0, bad = 0, p = -2, last_fs = -1, n_hs = 0, n_vs = 0, n_rgb = 0;
   always #5 clk = ~clk;
   vga_tile_scan #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .V_ACTIVE(VA),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .TILE_SHIFT(TS), .DRAW_LATENCY(1), .FG_COLOR(FG))
   dut_a (.i_clk(clk), .i_rst(rst), .i_draw(draw_a), .o_row(row_a), .o_col(col_a),
      .o_hsync(hs_a), .o_vsync(vs_a), .o_red(r_a), .o_grn(g_a), .o_blu(b_a), .o_frame_start(fs_a));
   vga_tile_scan #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .V_ACTIVE(VA),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .TILE_SHIFT(TS), .DRAW_LATENCY(3), .FG_COLOR(FG))
   dut_b (.i_clk(clk), .i_rst(rst), .i_draw(draw_b), .o_row(row_b), .o_col(col_b),
      .o_hsync(hs_b), .o_vsync(vs_b), .o_red(r_b), .o_grn(g_b), .o_blu(b_b), .o_frame_start(fs_b));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s p=%0d got=%0h exp=%0h", tag, p, got, exp);
      end
   endtask
   function automatic logic draw_f(input int fr, input logic [5:0] r, input logic [5:0] c);
      return fr % 2 == 1 ? 1'b1 : (r == 6'd2 && c == 6'd3);
   endfunction
   task automatic cycle();
      exp_t e, o;
      int h, v, fr;
      logic act;
      logic [5:0] er, ec;
      p++;
      if (p == -1) begin
         chk("row_idle", row_a, 6'h3f);
         chk("fs_idle", fs_a, 0);
      end
      if (p >= 0) begin
         h = p % HT;
         v = (p / HT) % VT;
         fr = p / F;
         act = h < HA && v < VA;
         er = act ? 6'(v >> TS) : 6'h3f;
         ec = act ? 6'(h >> TS) : 6'h3f;
         chk("row_a", row_a, er);
         chk("col_a", col_a, ec);
         chk("fs_a", fs_a, h == 0 && v == 0);
         chk("row_b", row_b, er);
         chk("col_b", col_b, ec);
         chk("fs_b", fs_b, h == 0 && v == 0);
         if (fs_a) begin
            if (last_fs >= 0) chk("fs_period", p - last_fs, F);
            last_fs = p;
         end
         e.q = p;
         e.hs = !(h >= HA + HF && h < HA + HF + HS);
         e.vs = !(v >= VA + VF && v < VA + VF + VS);
         e.rgb = act && draw_f(fr, er, ec) ? FG : 9'h0;
         qa.push_back(e);
         qb.push_back(e);
         dqa.push_back(draw_f(fr, row_a, col_a));
         dqb.push_back(draw_f(fr, row_b, col_b));
      end
      draw_a = dqa.size() > 1 ? dqa.pop_front() : 1'b0;
      draw_b = dqb.size() > 3 ? dqb.pop_front() : 1'b0;
      if (qa.size() > 2) begin
         o = qa.pop_front();
         chk("hs_a", hs_a, o.hs);
         chk("vs_a", vs_a, o.vs);
         chk("rgb_a", {r_a, g_a, b_a}, o.rgb);
         if (o.q % F == 0) begin
            n_hs = 0;
            n_vs = 0;
            n_rgb = 0;
         end
         if (!hs_a) n_hs++;
         if (!vs_a) n_vs++;
         if ({r_a, g_a, b_a} != 9'h0) n_rgb++;
         if (o.q % F == F - 1) begin
            chk("hs_low_frame", n_hs, HS * VT);
            chk("vs_low_frame", n_vs, VS * HT);
            chk("rgb_on_frame", n_rgb, (o.q / F) % 2 == 1 ? HA * VA : 64);
         end
      end
      if (qb.size() > 4) begin
         o = qb.pop_front();
         chk("hs_b", hs_b, o.hs);
         chk("vs_b", vs_b, o.vs);
         chk("rgb_b", {r_b, g_b, b_b}, o.rgb);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_row", row_a, 6'h3f);
      chk("rst_col", col_b, 6'h3f);
      chk("rst_hs", hs_a, 1);
      chk("rst_vs", vs_b, 1);
      chk("rst_rgb", {r_a, g_a, b_a}, 0);
      chk("rst_fs", fs_a, 0);
      rst = 0;
      repeat (3 * F + 30 * HT + 70 + 2) begin
         @(negedge clk);
         cycle();
      end
      chk("pre_abort_hs", hs_a, 0);
      #1 rst = 1;
      #1;
      chk("abort_row", row_a, 6'h3f);
      chk("abort_col", col_a, 6'h3f);
      chk("abort_hs", hs_a, 1);
      chk("abort_vs", vs_a, 1);
      chk("abort_rgb", {r_b, g_b, b_b}, 0);
      chk("abort_fs", fs_b, 0);
      @(negedge clk);
      p = -2;
      last_fs = -1;
      qa.delete();
      qb.delete();
      dqa.delete();
      dqb.delete();
      draw_a = 0;
      draw_b = 0;
      rst = 0;
      repeat (2 * F + 2) begin
         @(negedge clk);
         cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
